fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 143 ++++++++++++++
 tb/tb_fb_scanout.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: maps upstream VGA timing onto a 2x-scaled RGB332 framebuffer
// through a two-tick read pipeline, with frame-synchronous front/back buffer swapping.
module fb_scanout #(
    parameter int unsigned H_OFFSET = 160,
    parameter int unsigned FB_W     = 320,
    parameter int unsigned FB_H     = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_clk,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        draw_active,
    input  logic        screen_end,
    output logic [17:0] fb_addr,
    output logic        fb_rd_en,
    input  logic [7:0]  fb_rdata,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        front_buf,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam logic [0:0]  StIdle    = 1'b0;
    localparam logic [0:0]  StPending = 1'b1;
    localparam logic [16:0] FbWBits   = 17'(FB_W);
    localparam logic [16:0] FbSize    = 17'(FB_W * FB_H);

    logic [9:0]  dx;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [16:0] row_base;
    logic [16:0] offset;
    logic [16:0] sat_offset;

    logic        s1_de;
    logic        s1_hs;
    logic        s1_vs;
    logic [7:0]  rdata_q;
    logic [7:0]  pix_data;
    logic [0:0]  state_q;
    logic        frame_edge;

    // row * FB_W as a sum of shifted rows; FB_W is constant so this folds to adders.
    always_comb begin
        dx       = pix_x - 10'(H_OFFSET);
        col      = dx >> 1;
        row      = pix_y >> 1;
        row_base = '0;
        for (int i = 0; i < 17; i++) begin
            if (FbWBits[i]) begin
                row_base = row_base + (17'(row) << i);
            end
        end
        offset     = row_base + 17'(col);
        sat_offset = (offset >= FbSize) ? FbSize - 17'd1 : offset;
    end

    // With a tick every clk the read data arrives on the very tick that consumes it.
    assign pix_data   = fb_rd_en ? fb_rdata : rdata_q;
    assign frame_edge = pix_clk && screen_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
        end else begin
            fb_rd_en <= 1'b0;
            if (pix_clk) begin
                fb_addr  <= {front_buf, sat_offset};
                fb_rd_en <= draw_active;
                s1_de    <= draw_active;
                s1_hs    <= h_sync;
                s1_vs    <= v_sync;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
        end else begin
            if (fb_rd_en) begin
                rdata_q <= fb_rdata;
            end
            if (pix_clk) begin
                vga_hs <= s1_hs;
                vga_vs <= s1_vs;
                if (s1_de) begin
                    {red, green, blue} <= pix_data;
                end else begin
                    {red, green, blue} <= 8'h00;
                end
            end
        end
    end

    // Extra requests while pending are absorbed, so at most one toggle per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            front_buf <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (swap_req) begin
                        if (frame_edge) begin
                            front_buf <= ~front_buf;
                            swap_ack  <= 1'b1;
                        end else begin
                            state_q <= StPending;
                        end
                    end
                end
                StPending: begin
                    if (frame_edge) begin
                        front_buf <= ~front_buf;
                        swap_ack  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: colour/sync outputs checked against a scoreboard of
// per-tick expectations; address, read strobe and swap behaviour checked directly.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_clk = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic        draw_active = 1'b0;
    logic        screen_end = 1'b0;
    logic [17:0] fb_addr;
    logic        fb_rd_en;
    logic [7:0]  fb_rdata = '0;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        front_buf;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        vga_hs;
    logic        vga_vs;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [17:0] addr_seen;
    logic        rd_seen;
    logic        ack_seen;
    logic        front_seen;
    logic        ack_after;

    fb_scanout dut (
        .clk         (clk),
        .rst         (rst),
        .pix_clk     (pix_clk),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .draw_active (draw_active),
        .screen_end  (screen_end),
        .fb_addr     (fb_addr),
        .fb_rd_en    (fb_rd_en),
        .fb_rdata    (fb_rdata),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .front_buf   (front_buf),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected $finish)");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model_off(input int x, input int y);
        return 17'(((x - 160) / 2) + (y / 2) * 320);
    endfunction

    // One tick followed by three idle clks (pix_clk every 4th clk).
    task automatic do_tick(input logic [9:0] x, input logic [8:0] y, input logic de,
                           input logic hs, input logic vs, input logic se,
                           input logic [7:0] rd, input logic sr);
        exp_t e;
        exp_t got_exp;
        pix_x       = x;
        pix_y       = y;
        draw_active = de;
        h_sync      = hs;
        v_sync      = vs;
        screen_end  = se;
        fb_rdata    = rd;
        swap_req    = sr;
        pix_clk     = 1'b1;
        e.r  = de ? rd[7:5] : 3'd0;
        e.g  = de ? rd[4:2] : 3'd0;
        e.b  = de ? rd[1:0] : 2'd0;
        e.hs = hs;
        e.vs = vs;
        sb.push_back(e);
        step();
        pix_clk    = 1'b0;
        screen_end = 1'b0;
        swap_req   = 1'b0;
        addr_seen  = fb_addr;
        rd_seen    = fb_rd_en;
        ack_seen   = swap_ack;
        front_seen = front_buf;
        check("rd_en_on_tick", 32'(fb_rd_en), 32'(de));
        if (sb.size() >= 2) begin
            got_exp = sb.pop_front();
            check("colour", 32'({red, green, blue}), 32'({got_exp.r, got_exp.g, got_exp.b}));
            check("vga_hs", 32'(vga_hs), 32'(got_exp.hs));
            check("vga_vs", 32'(vga_vs), 32'(got_exp.vs));
        end
        step();
        ack_after = swap_ack;
        check("rd_en_idle", 32'(fb_rd_en), 32'd0);
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_rd_en", 32'(fb_rd_en), 32'd0);
        check("rst_colour", 32'({red, green, blue}), 32'd0);
        check("rst_hs", 32'(vga_hs), 32'd1);
        check("rst_vs", 32'(vga_vs), 32'd1);
        check("rst_front", 32'(front_buf), 32'd0);
        check("rst_ack", 32'(swap_ack), 32'd0);
        rst = 1'b0;
        step();

        // Pipeline: first visible pixel, then flush with further pixels.
        do_tick(10'd160, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hE3, 1'b0);
        check("addr_first", 32'(addr_seen), 32'd0);
        do_tick(10'd161, 9'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h1C, 1'b0);
        check("addr_161_1", 32'(addr_seen), 32'(model_off(161, 1)));
        check("colour_e3_r", 32'(red), 32'd7);
        check("colour_e3_g", 32'(green), 32'd0);
        check("colour_e3_b", 32'(blue), 32'd3);
        do_tick(10'd162, 9'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
        check("addr_162_2", 32'(addr_seen), 32'(model_off(162, 2)));
        do_tick(10'd799, 9'd479, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        check("addr_last", 32'(addr_seen), 32'(model_off(799, 479)));
        do_tick(10'd480, 9'd100, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
        check("addr_mid", 32'(addr_seen), 32'(model_off(480, 100)));

        // Blanking with h_sync active.
        do_tick(10'd20, 9'd100, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        check("blank_no_read", 32'(rd_seen), 32'd0);
        do_tick(10'd21, 9'd100, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        do_tick(10'd22, 9'd100, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        check("blank_hs_low", 32'(vga_hs), 32'd0);
        check("blank_colour", 32'({red, green, blue}), 32'd0);

        // Two requests mid-frame yield a single swap at the frame boundary.
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        check("pend_front", 32'(front_buf), 32'd0);
        do_tick(10'd300, 9'd200, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
        check("pend_no_ack", 32'(ack_seen), 32'd0);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        do_tick(10'd799, 9'd479, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0);
        check("swap_ack", 32'(ack_seen), 32'd1);
        check("swap_front", 32'(front_seen), 32'd1);
        check("swap_addr_old_buf", 32'(addr_seen[17]), 32'd0);
        check("swap_ack_pulse", 32'(ack_after), 32'd0);
        do_tick(10'd160, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
        check("new_buf_addr", 32'(addr_seen), 32'h20000);
        do_tick(10'd799, 9'd479, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0);
        check("absorbed_no_ack", 32'(ack_seen), 32'd0);
        check("absorbed_front", 32'(front_seen), 32'd1);

        // Request coinciding with the frame-end tick swaps immediately.
        do_tick(10'd799, 9'd479, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
        check("imm_ack", 32'(ack_seen), 32'd1);
        check("imm_front", 32'(front_seen), 32'd0);
        do_tick(10'd799, 9'd479, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b1);
        check("imm2_front", 32'(front_seen), 32'd1);

        // Reset while pending with front_buf=1.
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        do_tick(10'd200, 9'd10, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
        rst = 1'b1;
        step();
        check("mid_rst_front", 32'(front_buf), 32'd0);
        check("mid_rst_hs", 32'(vga_hs), 32'd1);
        check("mid_rst_vs", 32'(vga_vs), 32'd1);
        check("mid_rst_colour", 32'({red, green, blue}), 32'd0);
        check("mid_rst_ack", 32'(swap_ack), 32'd0);
        rst = 1'b0;
        sb.delete();
        step();
        do_tick(10'd799, 9'd479, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
        check("post_rst_no_ack", 32'(ack_seen), 32'd0);
        check("post_rst_front", 32'(front_seen), 32'd0);
        check("post_rst_addr", 32'(addr_seen), 32'(model_off(799, 479)));
        do_tick(10'd400, 9'd50, 1'b1, 1'b1, 1'b1, 1'b0, 8'h9B, 1'b0);
        do_tick(10'd402, 9'd50, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
